// File: rtl/fetch_unit_pkg.sv
// Shared pipeline types for the fetch stage.
// IF/ID bundle, fetch FSM states and constants.
package fetch_unit_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
  } if_data_t;

  typedef enum logic {
    ST_RUN,
    ST_FLUSH
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response channel.
// master = fetch side, slave = memory side.
interface fetch_unit_if;
  logic        req;
  logic [31:0] addr;
  logic        ready;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (
    output req, addr,
    input  ready, rvalid, rdata
  );

  modport slave (
    input  req, addr,
    output ready, rvalid, rdata
  );
endinterface

// File: rtl/fetch_unit_fifo.sv
// Small synchronous FIFO with flush.
// DEPTH must be a power of two.
module fetch_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;

  // pointer and occupancy bookkeeping
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // storage write, no reset needed
  always_ff @(posedge clk) begin
    if (push) mem[wp] <= din;
  end

  assign dout  = mem[rp];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage feeding IF/ID.
// In-order imem fetch, buffering and redirect flush.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2,
  parameter logic [31:0] NOP_INSTR  = fetch_unit_pkg::NOP_INSTR
) (
  input  logic                     clk,
  input  logic                     reset,
  fetch_unit_if.master             imem,
  input  logic                     redirect,
  input  logic [31:0]              redirect_pc,
  input  logic                     ifid_en,
  output logic                     out_valid,
  output fetch_unit_pkg::if_data_t out_data
);

  import fetch_unit_pkg::*;

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0] LIMIT = (CW+1)'(FIFO_DEPTH);

  logic [31:0]  pc, pc_d;
  logic [CW-1:0] outstanding, out_d;
  logic [CW-1:0] drop_cnt, drop_d;
  fetch_state_e  state, state_d;

  logic [CW-1:0] dcount, tcount;
  logic          dfull, dempty;
  logic          tfull, tempty;
  logic [31:0]   tag_pc;
  logic [$bits(if_data_t)-1:0] dhead;
  if_data_t      dpush_val;

  logic [CW:0] credit;
  logic        accept;
  logic        live_rsp;
  logic        dpush, dpop, tpop;

  assign credit   = {1'b0, outstanding} + {1'b0, dcount};
  assign imem.req = !reset && !redirect && (credit < LIMIT);
  assign imem.addr = pc;
  assign accept   = imem.req && imem.ready;

  assign live_rsp = imem.rvalid && (state == ST_RUN);
  assign tpop     = live_rsp && !redirect;
  assign dpush    = live_rsp && !redirect;
  assign dpop     = ifid_en && out_valid && !redirect;

  assign dpush_val = '{
    instr:    imem.rdata,
    pc:       tag_pc,
    pc_plus4: tag_pc + 32'd4
  };

  fetch_fifo #(
    .W     (32),
    .DEPTH (FIFO_DEPTH)
  ) u_tag (
    .clk   (clk),
    .reset (reset),
    .flush (redirect),
    .push  (accept),
    .din   (pc),
    .pop   (tpop),
    .dout  (tag_pc),
    .count (tcount),
    .full  (tfull),
    .empty (tempty)
  );

  fetch_fifo #(
    .W     ($bits(if_data_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_buf (
    .clk   (clk),
    .reset (reset),
    .flush (redirect),
    .push  (dpush),
    .din   (dpush_val),
    .pop   (dpop),
    .dout  (dhead),
    .count (dcount),
    .full  (dfull),
    .empty (dempty)
  );

  // buffer head, or a NOP bubble when empty
  always_comb begin
    out_valid = !dempty;
    out_data  = '{instr: NOP_INSTR, pc: '0, pc_plus4: '0};
    if (!dempty) out_data = if_data_t'(dhead);
  end

  // state, pc and counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      pc          <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
      state       <= ST_RUN;
    end else begin
      pc          <= pc_d;
      outstanding <= out_d;
      drop_cnt    <= drop_d;
      state       <= state_d;
    end
  end

  // next pc, credit counters and RUN/FLUSH transitions
  always_comb begin
    pc_d    = pc;
    out_d   = outstanding + CW'(accept) - CW'(imem.rvalid);
    drop_d  = drop_cnt;
    state_d = state;
    if (accept) pc_d = pc + 32'd4;
    unique case (state)
      ST_RUN: ;
      ST_FLUSH: begin
        if (imem.rvalid) begin
          drop_d = drop_cnt - 1'b1;
          if (drop_cnt == CW'(1)) state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
    if (redirect) begin
      pc_d    = {redirect_pc[31:2], 2'b00};
      drop_d  = outstanding - CW'(imem.rvalid);
      state_d = (drop_d != '0) ? ST_FLUSH : ST_RUN;
    end
  end

  logic        hold_q;
  if_data_t    held_q;

  // remember last cycle's stall condition for the stability check
  always_ff @(posedge clk) begin
    hold_q <= !reset && out_valid && !ifid_en && !redirect;
    held_q <= out_data;
  end

  // protocol and overflow checks
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(imem.rvalid && outstanding == '0))
        else $error("rvalid with nothing outstanding");
      assert (outstanding <= CW'(FIFO_DEPTH))
        else $error("outstanding overflow");
      assert (!(dpush && dfull && !dpop))
        else $error("buffer overflow");
      assert (!(accept && tfull))
        else $error("tag overflow");
      assert (!(tpop && tempty) && tcount <= CW'(FIFO_DEPTH))
        else $error("tag underflow");
      assert (!hold_q || out_data == held_q)
        else $error("head changed while stalled");
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus random
// traffic against a queue-based reference model.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        ifid_en;
  logic        out_valid;
  if_data_t    out_data;

  fetch_unit_if bus ();

  fetch_unit #(
    .RESET_PC   (32'h0),
    .FIFO_DEPTH (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .imem        (bus),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .ifid_en     (ifid_en),
    .out_valid   (out_valid),
    .out_data    (out_data)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(string tag, logic [95:0] got,
                       logic [95:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [31:0] a;
    bit          live;
  } fl_t;

  typedef struct {
    logic [31:0] a;
    int          due;
  } mr_t;

  fl_t         infl[$];
  if_data_t    obuf[$];
  logic [31:0] mpc = 32'h0;
  mr_t         mq[$];
  int          cyc = 0;
  int          lat = 1;
  bit          last_acc;
  bit          seen_bad;

  function automatic logic [31:0] memfun(logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9bdf;
  endfunction

  task automatic cycle(bit rst, bit rd, logic [31:0] rpc,
                       bit en, bit rdy);
    bit       rv;
    bit       ereq;
    if_data_t eh;
    fl_t      f;
    reset       = rst;
    redirect    = rd;
    redirect_pc = rpc;
    ifid_en     = en;
    bus.ready   = rdy;
    rv = !rst && mq.size() > 0 && mq[0].due <= cyc;
    bus.rvalid = rv;
    bus.rdata  = rv ? memfun(mq[0].a) : 32'h0;
    @(negedge clk);
    ereq = !rst && !rd && (infl.size() + obuf.size() < 2);
    check("req", 96'(bus.req), 96'(ereq));
    if (ereq) check("addr", 96'(bus.addr), 96'(mpc));
    check("ovalid", 96'(out_valid), 96'(obuf.size() != 0));
    eh = '{instr: NOP_INSTR, pc: 32'h0, pc_plus4: 32'h0};
    if (obuf.size() != 0) eh = obuf[0];
    check("odata", out_data, eh);
    if (out_valid && (out_data.pc == 32'h10 ||
                      out_data.pc == 32'h14))
      seen_bad = 1'b1;
    last_acc = bus.req && rdy;
    if (rst) mq.delete();
    else begin
      if (rv) void'(mq.pop_front());
      if (last_acc) mq.push_back('{bus.addr, cyc + lat});
    end
    @(posedge clk);
    if (rst) begin
      infl.delete();
      obuf.delete();
      mpc = 32'h0;
    end else if (rd) begin
      if (rv && infl.size() > 0) void'(infl.pop_front());
      foreach (infl[i]) infl[i].live = 1'b0;
      obuf.delete();
      mpc = {rpc[31:2], 2'b00};
    end else begin
      if (en && obuf.size() > 0) void'(obuf.pop_front());
      if (rv && infl.size() > 0) begin
        f = infl.pop_front();
        if (f.live)
          obuf.push_back('{memfun(f.a), f.a, f.a + 32'd4});
      end
      if (ereq && rdy) begin
        infl.push_back('{mpc, 1'b1});
        mpc = mpc + 32'd4;
      end
    end
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
  endtask

  int nacc;

  initial begin
    bus.ready  = 1'b0;
    bus.rvalid = 1'b0;
    bus.rdata  = 32'h0;

    // reset state
    do_reset();
    check("rst_drop", 96'(dut.drop_cnt), 96'(0));
    check("rst_addr", 96'(bus.addr), 96'(32'h0));

    // streaming, 1-cycle memory
    lat = 1;
    repeat (12) cycle(0, 0, 0, 1, 1);

    // stall: exactly two accepts, then release
    do_reset();
    nacc = 0;
    repeat (5) begin
      cycle(0, 0, 0, 0, 1);
      nacc += int'(last_acc);
    end
    check("stall_acc", 96'(nacc), 96'(2));
    repeat (6) cycle(0, 0, 0, 1, 1);

    // redirect with two in flight
    do_reset();
    lat = 3;
    cycle(0, 1, 32'h10, 1, 1);
    cycle(0, 0, 0, 1, 1);
    cycle(0, 0, 0, 1, 1);
    seen_bad = 1'b0;
    cycle(0, 1, 32'h100, 1, 1);
    check("flush_drop", 96'(dut.drop_cnt), 96'(2));
    check("flush_st", 96'(dut.state), 96'(ST_FLUSH));
    repeat (12) cycle(0, 0, 0, 1, 1);
    check("no_stale", 96'(seen_bad), 96'(0));

    // redirect colliding with rvalid and pop
    do_reset();
    lat = 1;
    cycle(0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 1);
    cycle(0, 1, 32'h40, 1, 1);
    check("rd_empty", 96'(out_valid), 96'(0));
    check("rd_st", 96'(dut.state), 96'(ST_RUN));
    repeat (4) cycle(0, 0, 0, 1, 1);

    // address wrap
    cycle(0, 1, 32'hFFFF_FFFE, 1, 1);
    check("wrap_addr", 96'(bus.addr), 96'(32'hFFFF_FFFC));
    repeat (6) cycle(0, 0, 0, 1, 1);

    // reset mid-operation
    lat = 3;
    cycle(0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 1);
    cycle(1, 0, 0, 0, 1);
    check("mr_valid", 96'(out_valid), 96'(0));
    check("mr_instr", 96'(out_data.instr), 96'(32'h13));
    check("mr_addr", 96'(bus.addr), 96'(32'h0));
    check("mr_drop", 96'(dut.drop_cnt), 96'(0));

    // random traffic
    repeat (3000) begin
      lat = $urandom_range(1, 4);
      cycle(($urandom % 100) == 0,
            ($urandom % 16) == 0,
            (($urandom % 8) == 0) ? 32'hFFFF_FFFE : $urandom,
            ($urandom % 4) != 0,
            ($urandom % 3) != 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
